// File: rtl/branch_predictor.sv
// Direct-mapped BTB of 2-bit saturating counters: zero-latency lookup on the
// fetch PC, single-port training from execute, branch/mispredict counters.
module branch_predictor #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_f,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             upd_en,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_pred,
    output logic             mispredict,
    output logic [31:0]      branch_count,
    output logic [31:0]      mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = WIDTH - IDX - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;

    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;

    // Byte-offset bits of both PCs take no part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc_f[1:0], upd_pc[1:0]};

    // Lookup reads the registered table only, so a same-cycle update is not seen.
    assign rd_idx      = pc_f[IDX+1:2];
    assign rd_tag      = pc_f[WIDTH-1:IDX+2];
    assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
    assign pred_target = rd_hit ? target_q[rd_idx] : '0;

    assign wr_idx = upd_pc[IDX+1:2];
    assign wr_tag = upd_pc[WIDTH-1:IDX+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    assign mispredict = upd_en && (upd_pred != upd_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (upd_en) begin
            if (wr_hit) begin
                if (upd_taken) begin
                    ctr_q[wr_idx]    <= ctr_inc(ctr_q[wr_idx]);
                    target_q[wr_idx] <= upd_target;
                end else begin
                    ctr_q[wr_idx] <= ctr_dec(ctr_q[wr_idx]);
                end
            end else if (upd_taken) begin
                // Only a taken branch may evict whatever currently owns the slot.
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= upd_target;
                ctr_q[wr_idx]    <= CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (upd_en) begin
            branch_count <= branch_count + 32'd1;
            if (mispredict) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule
